// File: rtl/pd_pkg.sv
// Shared types and sizing constants for the serial pattern detector.
// The len/window widths are fixed by the configuration bus.
package pd_pkg;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = 4;
  localparam int WIN_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_detect_ctrl_if.sv
// Configuration, control, serial data and status bundle of the pattern detector.
// The master side drives configuration and stimulus; the slave side is the detector.
interface pattern_detect_ctrl_if #(
  parameter int MAX_LEN = pd_pkg::MAX_LEN,
  parameter int CNT_W   = pd_pkg::CNT_W
);
  import pd_pkg::*;

  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [WIN_W-1:0]   cfg_window;
  logic               start;
  logic               abort;
  logic               data_in;
  logic               busy;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;
  logic               done;
  logic               err_cfg;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_window, start, abort, data_in,
    input  busy, out, match_cnt, done, err_cfg
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_window, start, abort, data_in,
    output busy, out, match_cnt, done, err_cfg
  );

endinterface

// File: rtl/pd_matcher.sv
// Shift register, fill tracking and combinational hit compare for one serial bit per cycle.
// The hit is evaluated on the incoming bit so the controller can register it as a Mealy pulse.
module pd_matcher #(
  parameter int MAX_LEN = pd_pkg::MAX_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic                     i_bit,
  input  logic [MAX_LEN-1:0]       i_pattern,
  input  logic [pd_pkg::LEN_W-1:0] i_len,
  input  logic                     i_overlap,
  output logic                     o_hit
);
  import pd_pkg::*;

  localparam int FILL_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-2:0] r_shift;
  logic [FILL_W-1:0]  r_fill;
  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic [FILL_W:0]    w_fill_p1;
  logic [FILL_W-1:0]  w_fill_sat;
  logic               w_hit;

  // Candidate window including the incoming bit, length mask and saturating fill.
  always_comb begin
    w_window  = {r_shift, i_bit};
    w_mask    = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(i_len));
    end
    w_fill_p1 = {1'b0, r_fill} + {{FILL_W{1'b0}}, 1'b1};
    if (r_fill >= FILL_W'(MAX_LEN)) begin
      w_fill_sat = r_fill;
    end else begin
      w_fill_sat = r_fill + {{(FILL_W-1){1'b0}}, 1'b1};
    end
    w_hit = (int'(w_fill_p1) >= int'(i_len)) &&
            ((w_window & w_mask) == (i_pattern & w_mask));
  end

  // History update; a non-overlapping hit restarts the fill so matches cannot share bits.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_shift <= {(MAX_LEN-1){1'b0}};
      r_fill  <= {FILL_W{1'b0}};
    end else if (i_en) begin
      r_shift <= w_window[MAX_LEN-2:0];
      r_fill  <= (w_hit && !i_overlap) ? {FILL_W{1'b0}} : w_fill_sat;
    end else begin
      r_shift <= r_shift;
      r_fill  <= r_fill;
    end
  end

  assign o_hit = w_hit;

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Run controller for the serial pattern detector: configuration registers, IDLE/ARM/RUN/DONE
// sequencing, bit and match counters, and registered status outputs.
module pattern_detect_ctrl #(
  parameter int MAX_LEN = pd_pkg::MAX_LEN,
  parameter int CNT_W   = pd_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  pattern_detect_ctrl_if.slave bus
);
  import pd_pkg::*;

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [WIN_W-1:0]   r_window;
  logic [WIN_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic               r_busy;
  logic               r_out;
  logic               r_done;

  logic               w_cfg_ok;
  logic               w_hit;
  logic               w_clear;
  logic               w_en;
  logic [WIN_W-1:0]   w_bit_next;

  assign w_cfg_ok   = (bus.cfg_len != {LEN_W{1'b0}}) &&
                      (int'(bus.cfg_len) <= MAX_LEN) &&
                      (bus.cfg_window != {WIN_W{1'b0}});
  assign w_clear    = (r_state == ST_ARM);
  assign w_en       = (r_state == ST_RUN) && !bus.abort;
  assign w_bit_next = r_bit_cnt + {{(WIN_W-1){1'b0}}, 1'b1};

  pd_matcher #(.MAX_LEN(MAX_LEN)) u_matcher (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_en      (w_en),
    .i_bit     (bus.data_in),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .i_overlap (r_overlap),
    .o_hit     (w_hit)
  );

  // Run sequencing with registered outputs; rst overrides every other control.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pattern <= {MAX_LEN{1'b0}};
      r_len     <= LEN_W'(1);
      r_overlap <= 1'b0;
      r_window  <= WIN_W'(1);
      r_bit_cnt <= {WIN_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_out     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_out  <= 1'b0;
          r_done <= 1'b0;
          if (bus.cfg_we) begin
            if (w_cfg_ok) begin
              r_pattern <= bus.cfg_pattern;
              r_len     <= bus.cfg_len;
              r_overlap <= bus.cfg_overlap;
              r_window  <= bus.cfg_window;
              r_err     <= 1'b0;
            end else begin
              r_err     <= 1'b1;
            end
          end else if (bus.start && !r_err) begin
            r_state <= ST_ARM;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ARM: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_bit_cnt <= {WIN_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_out   <= 1'b0;
          end else begin
            r_bit_cnt <= w_bit_next;
            r_out     <= w_hit;
            if (w_hit && (r_cnt != {CNT_W{1'b1}})) begin
              r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // The last window bit is still scored above before leaving RUN.
            if (w_bit_next == r_window) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_out   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_out   <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out       = r_out;
  assign bus.match_cnt = r_cnt;
  assign bus.done      = r_done;
  assign bus.err_cfg   = r_err;

endmodule
